share_compress_pipe: RTL

Parametrised, back-pressured successor to the Boolean share-compression unit in the B2A datapath. It takes N_SHARES Boolean shares of a K_WIDTH word and unmasks them into a single value. The shares pass through a registered binary tree of refresh-then-XOR layers. Tree randomness is sampled once per transaction and carried down the pipeline with the data. The block sits at the tail of the masked B2A pipeline and adds ready/valid flow control and randomness-starvation handling.

---
 rtl/share_compress_pkg.sv | 45 ++++
 rtl/share_compress_layer.sv | 107 ++++++++++
 rtl/share_compress_pipe.sv | 109 ++++++++++
 3 files changed

// File: rtl/share_compress_pkg.sv
// share_compress_pkg
//   Shared constants and elaboration-time helpers for the share compression
//   tree (share_compress_layer, share_compress_pipe).
//   - num_layers   : register layers needed to fold n shares down to one
//   - shares_at    : share count entering layer l (M_l)
//   - rand_num     : fresh random words per transaction (one per pair)
//   - rand_offset  : index of the first random word consumed by layer l
//   - word_slots   : word count clamped to >= 1 so no bus is zero width
//   - n_shares_legal / N_SHARES_MIN / N_SHARES_MAX : legal share counts
package share_compress_pkg;

   localparam int unsigned N_SHARES_MIN = 2;
   localparam int unsigned N_SHARES_MAX = 16;

   function automatic bit n_shares_legal(input int unsigned n);
      return (n >= N_SHARES_MIN) && (n <= N_SHARES_MAX);
   endfunction

   function automatic int unsigned num_layers(input int unsigned n);
      return $clog2(n);
   endfunction

   // M_0 = n, M_{l+1} = ceil(M_l / 2)
   function automatic int unsigned shares_at(input int unsigned n, input int unsigned l);
      int unsigned m = n;
      for (int unsigned i = 0; i < l; i++) m = (m + 1) / 2;
      return m;
   endfunction

   function automatic int unsigned rand_num(input int unsigned n);
      return n - 1;
   endfunction

   // Random words are numbered layer 0 pairs first, then layer 1, and so on.
   function automatic int unsigned rand_offset(input int unsigned n, input int unsigned l);
      int unsigned off = 0;
      for (int unsigned i = 0; i < l; i++) off += shares_at(n, i) / 2;
      return off;
   endfunction

   function automatic int unsigned word_slots(input int unsigned w);
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/share_compress_layer.sv
// share_compress_layer
//   One registered refresh-then-XOR layer of the compression tree.
//   Pair j refreshes shares 2j and 2j+1 with the same random word and
//   registers both halves; the next layer sees their XOR as share j.
//   An odd trailing share is registered unchanged. Random words not used
//   here are registered alongside the data so they stay with their
//   transaction.
//   Optional macro SHARE_COMPRESS_ZEROIZE_EN: a bubble loads zeros into the
//   data and randomness registers instead of don't-care values.
//
//   Ports
//     clk_i, rst_ni : clock, async active-low reset
//     i_adv         : pipeline advance; all registers hold when low
//     i_vld         : valid bit of the incoming slot
//     i_s           : M input shares, share s at [s*K_WIDTH +: K_WIDTH]
//     i_r           : RW_IN random words, word 0 serves pair 0
//     o_vld         : registered valid bit
//     o_s           : ceil(M/2) output shares
//     o_r           : remaining random words for later layers (0 if none)
module share_compress_layer
   import share_compress_pkg::*;
#(
   parameter int unsigned K_WIDTH = 32,
   parameter int unsigned M       = 3,
   parameter int unsigned RW_IN   = 2
) (
   input  logic                                        clk_i,
   input  logic                                        rst_ni,
   input  logic                                        i_adv,
   input  logic                                        i_vld,
   input  logic [M*K_WIDTH-1:0]                        i_s,
   input  logic [RW_IN*K_WIDTH-1:0]                    i_r,
   output logic                                        o_vld,
   output logic [((M+1)/2)*K_WIDTH-1:0]                o_s,
   output logic [word_slots(RW_IN-M/2)*K_WIDTH-1:0]    o_r
);

   localparam int unsigned KW       = K_WIDTH;
   localparam int unsigned PAIRS    = M / 2;
   localparam int unsigned RW_OUT   = RW_IN - PAIRS;
   localparam int unsigned RW_OUT_W = word_slots(RW_OUT);

   logic                  ld_clr;
   logic                  vld_q;
   logic [2*PAIRS*KW-1:0] pq_d;
   logic [2*PAIRS*KW-1:0] pq_q;

`ifdef SHARE_COMPRESS_ZEROIZE_EN
   assign ld_clr = ~i_vld;
`else
   assign ld_clr = 1'b0;
`endif

   always_comb begin
      // NOTE: default first so no path leaves pq_d unassigned (no latch).
      pq_d = '0;
      for (int j = 0; j < PAIRS; j++) begin
         pq_d[(2*j)*KW   +: KW] = i_s[(2*j)*KW   +: KW] ^ i_r[j*KW +: KW];
         pq_d[(2*j+1)*KW +: KW] = i_s[(2*j+1)*KW +: KW] ^ i_r[j*KW +: KW];
      end
   end

   // NOTE: data registers are reset as well, so o_z is a defined 0 out of reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q <= 1'b0;
         pq_q  <= '0;
      end else if (i_adv) begin
         // NOTE: non-blocking so every stage samples pre-edge values.
         vld_q <= i_vld;
         pq_q  <= ld_clr ? '0 : pq_d;
      end
   end

   assign o_vld = vld_q;

   for (genvar j = 0; j < PAIRS; j++) begin : g_pair
      assign o_s[j*KW +: KW] = pq_q[(2*j)*KW +: KW] ^ pq_q[(2*j+1)*KW +: KW];
   end

   if (M % 2 == 1) begin : g_odd
      logic [KW-1:0] odd_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            odd_q <= '0;
         end else if (i_adv) begin
            odd_q <= ld_clr ? '0 : i_s[(M-1)*KW +: KW];
         end
      end
      assign o_s[PAIRS*KW +: KW] = odd_q;
   end

   if (RW_OUT > 0) begin : g_rand
      logic [RW_OUT_W*KW-1:0] r_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_q <= '0;
         end else if (i_adv) begin
            r_q <= ld_clr ? '0 : i_r[RW_IN*KW-1 : PAIRS*KW];
         end
      end
      assign o_r = r_q;
   end else begin : g_no_rand
      assign o_r = '0;
   end

endmodule

// File: rtl/share_compress_pipe.sv
// share_compress_pipe
//   Back-pressured Boolean share compression: unmasks N_SHARES shares of a
//   K_WIDTH word through $clog2(N_SHARES) registered refresh/XOR layers.
//   All random words are sampled at acceptance and travel with the data.
//   Optional macro SHARE_COMPRESS_ZEROIZE_EN: bubbles clear the tree, so
//   o_z reads 0 whenever o_dvld is 0.
//
//   Ports
//     clk_i, rst_ni : clock, async active-low reset
//     i_dvld        : input shares valid
//     i_rvld        : randomness valid (input is only taken with both)
//     o_ready       : block advances this cycle (can accept)
//     i_x           : shares, share s at [s*K_WIDTH +: K_WIDTH]
//     i_n           : N_SHARES-1 random words, word k at [k*K_WIDTH +: K_WIDTH]
//     o_z           : unmasked result (XOR of final p/q registers)
//     o_dvld        : o_z valid
//     i_ready       : downstream accepts o_z
//     o_busy        : any stage holds a valid transaction
module share_compress_pipe
   import share_compress_pkg::*;
#(
   parameter int unsigned K_WIDTH  = 32,
   parameter int unsigned N_SHARES = 3
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  i_dvld,
   input  logic                                  i_rvld,
   output logic                                  o_ready,
   input  logic [K_WIDTH*N_SHARES-1:0]           i_x,
   input  logic [K_WIDTH*rand_num(N_SHARES)-1:0] i_n,
   output logic [K_WIDTH-1:0]                    o_z,
   output logic                                  o_dvld,
   input  logic                                  i_ready,
   output logic                                  o_busy
);

   localparam int unsigned LAYERS      = num_layers(N_SHARES);
   localparam int unsigned RANDNUM     = rand_num(N_SHARES);
   localparam bit          N_SHARES_OK = n_shares_legal(N_SHARES);

   if (!N_SHARES_OK) begin : g_bad_n_shares
      $error("share_compress_pipe: N_SHARES must be within 2..16");
   end

   logic              advance;
   logic              accept;
   logic [LAYERS-1:0] busy_v;

   // The whole pipe moves as one: it only stalls when a finished result is
   // waiting and downstream refuses it.
   assign advance = ~o_dvld | i_ready;
   assign o_ready = advance;
   assign accept  = i_dvld & i_rvld & advance;

   for (genvar l = 0; l < LAYERS; l++) begin : g_layer
      localparam int unsigned M_IN     = shares_at(N_SHARES, l);
      localparam int unsigned M_OUT    = shares_at(N_SHARES, l + 1);
      localparam int unsigned RW_IN    = RANDNUM - rand_offset(N_SHARES, l);
      localparam int unsigned RW_OUT_W = word_slots(RW_IN - M_IN / 2);

      logic                          vld_in;
      logic [M_IN*K_WIDTH-1:0]       s_in;
      logic [RW_IN*K_WIDTH-1:0]      r_in;
      logic                          vld_out;
      logic [M_OUT*K_WIDTH-1:0]      s_out;
      logic [RW_OUT_W*K_WIDTH-1:0]   r_out;

      if (l == 0) begin : g_head
         // A bubble enters stage 0 whenever nothing is accepted.
         assign vld_in = accept;
         assign s_in   = i_x;
         assign r_in   = i_n;
      end else begin : g_body
         assign vld_in = g_layer[l-1].vld_out;
         assign s_in   = g_layer[l-1].s_out;
         assign r_in   = g_layer[l-1].r_out;
      end

      share_compress_layer #(
         .K_WIDTH (K_WIDTH),
         .M       (M_IN),
         .RW_IN   (RW_IN)
      ) u_layer (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .i_adv  (advance),
         .i_vld  (vld_in),
         .i_s    (s_in),
         .i_r    (r_in),
         .o_vld  (vld_out),
         .o_s    (s_out),
         .o_r    (r_out)
      );

      assign busy_v[l] = vld_out;

      if (l == LAYERS - 1) begin : g_tail
         // The last layer consumes its final word; its randomness output is empty.
         logic unused_r;
         assign unused_r = ^r_out;
      end
   end

   assign o_z    = g_layer[LAYERS-1].s_out;
   assign o_dvld = g_layer[LAYERS-1].vld_out;
   assign o_busy = |busy_v;

endmodule
